// File: rtl/fp_acc_pkg.sv
// fp_acc_pkg: FSM state type and FP32 field constants shared by the accumulator files
package fp_acc_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FIRST, S_NEXT, S_WAIT, S_OUT} fp_acc_state_t;
  localparam int FP_EXP_MSB = 30;
  localparam int FP_EXP_LSB = 23;
  localparam logic [7:0] FP_EXP_MAX = 8'hFF;
  localparam logic [31:0] FP_SAT = 32'h7F7FFFFF;
endpackage

// File: rtl/fp_accumulator_if.sv
// fp_accumulator_if: start/len, term stream, adder operands/result, final-sum stream, busy; slave = accumulator side
interface fp_accumulator_if #(parameter int MAX_TERMS = 16);
  localparam int CNT_W = $clog2(MAX_TERMS + 1);
  logic start;
  logic [CNT_W-1:0] len;
  logic in_valid;
  logic in_ready;
  logic [31:0] in_data;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_y;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_data;
  logic out_err;
  logic busy;
  modport slave(input start, len, in_valid, in_data, add_y, out_ready,
                output in_ready, add_a, add_b, out_valid, out_data, out_err, busy);
  modport master(output start, len, in_valid, in_data, add_y, out_ready,
                 input in_ready, add_a, add_b, out_valid, out_data, out_err, busy);
endinterface

// File: rtl/fp_classify.sv
// fp_classify: flags an FP32 word as zero (bits[30:0]==0), negative (sign set) or special (exponent all ones)
module fp_classify
  import fp_acc_pkg::*;
(
  input  logic [31:0] i_word,
  output logic        is_zero,
  output logic        is_neg,
  output logic        is_special
);
  assign is_zero = i_word[30:0] == '0;
  assign is_neg = i_word[31];
  assign is_special = i_word[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_MAX;
endmodule

// File: rtl/fp_accumulator.sv
// fp_accumulator: sums len FP32 terms via an external adder (ports clk, reset, bus slave); FP_ACC_ERR_CHECK_EN adds term/overflow error checks
module fp_accumulator
  import fp_acc_pkg::*;
#(
  parameter int MAX_TERMS = 16,
  parameter int ADD_WAIT = 1
) (
  input logic clk,
  input logic reset,
  fp_accumulator_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_TERMS + 1);
  fp_acc_state_t r_state;
  logic [31:0] r_acc, r_add_a, r_add_b;
  logic [CNT_W-1:0] r_rem;
  logic [3:0] r_wcnt;
  logic r_err;
  logic w_is_zero, w_is_neg, w_is_special, w_skip, w_bad, w_ovf, w_last;
  logic [CNT_W-1:0] w_len;
  fp_classify u_cls(.i_word(bus.in_data), .is_zero(w_is_zero), .is_neg(w_is_neg), .is_special(w_is_special));
`ifdef FP_ACC_ERR_CHECK_EN
  assign w_bad = w_is_neg | w_is_special;
  assign w_ovf = bus.add_y[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_MAX;
  assign bus.out_err = r_err;
`else
  logic w_unused;
  assign w_bad = 1'b0;
  assign w_ovf = 1'b0;
  assign bus.out_err = 1'b0;
  assign w_unused = w_is_neg | w_is_special | r_err;
`endif
  assign w_skip = w_is_zero | w_bad;
  assign w_last = r_rem == CNT_W'(1);
  assign w_len = (bus.len > CNT_W'(MAX_TERMS)) ? CNT_W'(MAX_TERMS) : bus.len;
  assign bus.in_ready = (r_state == S_FIRST) || (r_state == S_NEXT);
  assign bus.out_valid = r_state == S_OUT;
  assign bus.busy = r_state != S_IDLE;
  assign bus.out_data = r_acc;
  assign bus.add_a = r_add_a;
  assign bus.add_b = r_add_b;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_acc <= '0;
      r_add_a <= '0;
      r_add_b <= '0;
      r_rem <= '0;
      r_wcnt <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_rem <= w_len;
          r_acc <= '0;
          r_err <= 1'b0;
          r_state <= (w_len == '0) ? S_OUT : S_FIRST;
        end
        S_FIRST: if (bus.in_valid) begin
          r_acc <= w_skip ? '0 : bus.in_data;
          r_err <= r_err | w_bad;
          r_rem <= r_rem - 1'b1;
          r_state <= w_last ? S_OUT : S_NEXT;
        end
        S_NEXT: if (bus.in_valid) begin
          r_rem <= r_rem - 1'b1;
          r_err <= r_err | w_bad;
          if (!w_skip && r_acc != '0) begin
            r_add_a <= r_acc;
            r_add_b <= bus.in_data;
            r_wcnt <= 4'(ADD_WAIT - 1);
            r_state <= S_WAIT;
          end else begin
            if (!w_skip) r_acc <= bus.in_data;
            r_state <= w_last ? S_OUT : S_NEXT;
          end
        end
        S_WAIT: if (r_wcnt != 4'd0) r_wcnt <= r_wcnt - 4'd1;
        else begin
          r_acc <= w_ovf ? FP_SAT : bus.add_y;
          r_err <= r_err | w_ovf;
          r_state <= (r_rem == '0) ? S_OUT : S_NEXT;
        end
        S_OUT: if (bus.out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
